// File: rtl/pipeline_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipeline_control                                             |
// | Description : Pipelined control unit for a 5-stage MIPS core. Decodes the  |
// |               ID instruction, carries EX/MEM/WB control through internal   |
// |               ID/EX, EX/MEM and MEM/WB registers, detects RAW / load-use   |
// |               hazards, drives stall/flush/PC select and generates EX-stage |
// |               forwarding selects.                                          |
// | Ports       : clk_i, rst_i (async, active-high)                            |
// |               op_i, funct_i, rs_i, rt_i, rd_i : ID instruction fields      |
// |               eq_i        : EX operand-equal flag                          |
// |               ex_ctrl_o   : {ALUop, ALUsrc} of the EX instruction          |
// |               ex_fwd_a_o/ex_fwd_b_o : 00 regfile, 01 MEM/WB, 10 EX/MEM     |
// |               mem_ctrl_o/mem_dst_o  : {MEM_cs, MEM_we}, EX/MEM dst         |
// |               wb_ctrl_o/wb_dst_o    : {Reg_we, mem_to_reg}, MEM/WB dst     |
// |               stall_o, flush_o, pc_sel_o, illegal_o                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipeline_control #(
  parameter int ALUOP_W = 3,
  parameter int REG_W   = 5,
  parameter bit FWD_EN  = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [5:0]         op_i,
  input  logic [5:0]         funct_i,
  input  logic [REG_W-1:0]   rs_i,
  input  logic [REG_W-1:0]   rt_i,
  input  logic [REG_W-1:0]   rd_i,
  input  logic               eq_i,
  output logic [ALUOP_W:0]   ex_ctrl_o,
  output logic [1:0]         ex_fwd_a_o,
  output logic [1:0]         ex_fwd_b_o,
  output logic [1:0]         mem_ctrl_o,
  output logic [REG_W-1:0]   mem_dst_o,
  output logic [1:0]         wb_ctrl_o,
  output logic [REG_W-1:0]   wb_dst_o,
  output logic               stall_o,
  output logic               flush_o,
  output logic [1:0]         pc_sel_o,
  output logic               illegal_o
);

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_j     = 6'b000010;

  localparam logic [5:0] c_fn_add   = 6'b100000;
  localparam logic [5:0] c_fn_sub   = 6'b100010;
  localparam logic [5:0] c_fn_and   = 6'b100100;
  localparam logic [5:0] c_fn_or    = 6'b100101;
  localparam logic [5:0] c_fn_mul   = 6'b011000;

  localparam logic [ALUOP_W-1:0] c_alu_add = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] c_alu_sub = ALUOP_W'(3'b110);
  localparam logic [ALUOP_W-1:0] c_alu_and = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] c_alu_or  = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] c_alu_mul = ALUOP_W'(3'b011);

  // rs/rt hold the registers the instruction actually reads, or 0 when the
  // field is not a source; register 0 then never produces a hazard match.
  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               mem_cs;
    logic               mem_we;
    logic               reg_we;
    logic               mem_to_reg;
    logic [REG_W-1:0]   dst;
    logic               illegal;
    logic               branch;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
  } idex_t;

  typedef struct packed {
    logic               mem_cs;
    logic               mem_we;
    logic               reg_we;
    logic               mem_to_reg;
    logic [REG_W-1:0]   dst;
  } exmem_t;

  typedef struct packed {
    logic               reg_we;
    logic               mem_to_reg;
    logic [REG_W-1:0]   dst;
  } memwb_t;

  idex_t              r_idex;
  exmem_t             r_exmem;
  memwb_t             r_memwb;
  idex_t              w_dec;
  logic               w_rs_used;
  logic               w_rt_used;
  logic               w_is_j;
  logic               w_r_valid;
  logic [ALUOP_W-1:0] w_r_alu;
  logic               w_hit_ex;
  logic               w_stall_cond;
  logic               w_taken;
  logic               w_jump;
  logic [1:0]         w_fwd_a;
  logic [1:0]         w_fwd_b;

  // Writer in a later stage targets a non-zero register that matches a or b.
  function automatic logic f_hit(input logic             we,
                                 input logic [REG_W-1:0] dst,
                                 input logic [REG_W-1:0] a,
                                 input logic [REG_W-1:0] b);
    return we && (dst != '0) && ((dst == a) || (dst == b));
  endfunction

  // ID decode
  always_comb begin
    w_dec     = '0;
    w_rs_used = 1'b1;
    w_rt_used = 1'b0;
    w_is_j    = 1'b0;
    w_r_valid = 1'b1;
    w_r_alu   = '0;

    case (funct_i)
      c_fn_add: w_r_alu = c_alu_add;
      c_fn_sub: w_r_alu = c_alu_sub;
      c_fn_and: w_r_alu = c_alu_and;
      c_fn_or:  w_r_alu = c_alu_or;
      c_fn_mul: w_r_alu = c_alu_mul;
      default:  w_r_valid = 1'b0;
    endcase

    case (op_i)
      c_op_rtype: begin
        w_rt_used = 1'b1;
        if (w_r_valid) begin
          w_dec.alu_op = w_r_alu;
          w_dec.reg_we = 1'b1;
          w_dec.dst    = rd_i;
        end else begin
          w_dec.illegal = 1'b1;
        end
      end
      c_op_addi: begin
        w_dec.alu_op  = c_alu_add;
        w_dec.alu_src = 1'b1;
        w_dec.reg_we  = 1'b1;
        w_dec.dst     = rt_i;
      end
      c_op_lw: begin
        w_dec.alu_op     = c_alu_add;
        w_dec.alu_src    = 1'b1;
        w_dec.mem_cs     = 1'b1;
        w_dec.reg_we     = 1'b1;
        w_dec.mem_to_reg = 1'b1;
        w_dec.dst        = rt_i;
      end
      c_op_sw: begin
        w_rt_used     = 1'b1;
        w_dec.alu_op  = c_alu_add;
        w_dec.alu_src = 1'b1;
        w_dec.mem_cs  = 1'b1;
        w_dec.mem_we  = 1'b1;
      end
      c_op_beq: begin
        w_rt_used    = 1'b1;
        w_dec.alu_op = c_alu_sub;
        w_dec.branch = 1'b1;
      end
      c_op_j: begin
        w_rs_used = 1'b0;
        w_is_j    = 1'b1;
      end
      default: w_dec.illegal = 1'b1;
    endcase

    w_dec.rs = w_rs_used ? rs_i : '0;
    w_dec.rt = w_rt_used ? rt_i : '0;
  end

  assign w_hit_ex = f_hit(r_idex.reg_we, r_idex.dst, w_dec.rs, w_dec.rt);

  generate
    if (FWD_EN) begin : g_fwd
      // Only a load in EX cannot be bypassed in time.
      assign w_stall_cond = w_hit_ex && r_idex.mem_to_reg;
      // The younger EX/MEM result takes priority over MEM/WB.
      assign w_fwd_a = f_hit(r_exmem.reg_we, r_exmem.dst, r_idex.rs, r_idex.rs) ? 2'b10 :
                       f_hit(r_memwb.reg_we, r_memwb.dst, r_idex.rs, r_idex.rs) ? 2'b01 : 2'b00;
      assign w_fwd_b = f_hit(r_exmem.reg_we, r_exmem.dst, r_idex.rt, r_idex.rt) ? 2'b10 :
                       f_hit(r_memwb.reg_we, r_memwb.dst, r_idex.rt, r_idex.rt) ? 2'b01 : 2'b00;
    end else begin : g_nofwd
      logic w_hit_mem;
      // MEM/WB is excluded: the regfile writes in the first half-cycle.
      assign w_hit_mem    = f_hit(r_exmem.reg_we, r_exmem.dst, w_dec.rs, w_dec.rt);
      assign w_stall_cond = w_hit_ex || w_hit_mem;
      assign w_fwd_a      = 2'b00;
      assign w_fwd_b      = 2'b00;
    end
  endgenerate

  // A taken branch squashes the ID instruction, so it overrides stall and jump.
  assign w_taken = r_idex.branch && eq_i;
  assign w_jump  = w_is_j && !w_taken && !w_stall_cond;

  assign stall_o    = !rst_i && w_stall_cond && !w_taken;
  assign flush_o    = !rst_i && (w_taken || w_jump);
  assign pc_sel_o   = rst_i   ? 2'b00 :
                      w_taken ? 2'b01 :
                      w_jump  ? 2'b10 : 2'b00;
  assign ex_fwd_a_o = w_fwd_a;
  assign ex_fwd_b_o = w_fwd_b;

  assign ex_ctrl_o  = {r_idex.alu_op, r_idex.alu_src};
  assign illegal_o  = r_idex.illegal;
  assign mem_ctrl_o = {r_exmem.mem_cs, r_exmem.mem_we};
  assign mem_dst_o  = r_exmem.dst;
  assign wb_ctrl_o  = {r_memwb.reg_we, r_memwb.mem_to_reg};
  assign wb_dst_o   = r_memwb.dst;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idex  <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
    end else begin
      if (w_taken || w_stall_cond) begin
        r_idex <= '0;
      end else begin
        r_idex <= w_dec;
      end
      r_exmem <= '{mem_cs:     r_idex.mem_cs,
                   mem_we:     r_idex.mem_we,
                   reg_we:     r_idex.reg_we,
                   mem_to_reg: r_idex.mem_to_reg,
                   dst:        r_idex.dst};
      r_memwb <= '{reg_we:     r_exmem.reg_we,
                   mem_to_reg: r_exmem.mem_to_reg,
                   dst:        r_exmem.dst};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipeline_control                                          |
// | Description : Self-checking bench for pipeline_control. Drives one shared  |
// |               instruction stream into a forwarding and a non-forwarding    |
// |               instance and compares both against a stage-list model.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pipeline_control;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR = 6'b100101, FN_MUL = 6'b011000, FN_BAD = 6'b000111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = OP_J, funct = 6'd0;
  logic [4:0] rs = 5'd0, rt = 5'd0, rd = 5'd0;
  logic       eq = 1'b0;

  always #5 clk = ~clk;

  logic [3:0] ex_ctrl1, ex_ctrl0;
  logic [1:0] fa1, fb1, mc1, wc1, ps1, fa0, fb0, mc0, wc0, ps0;
  logic [4:0] md1, wd1, md0, wd0;
  logic       st1, fl1, il1, st0, fl0, il0;

  pipeline_control #(.ALUOP_W(3), .REG_W(5), .FWD_EN(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst), .op_i(op), .funct_i(funct), .rs_i(rs), .rt_i(rt), .rd_i(rd),
    .eq_i(eq), .ex_ctrl_o(ex_ctrl1), .ex_fwd_a_o(fa1), .ex_fwd_b_o(fb1), .mem_ctrl_o(mc1),
    .mem_dst_o(md1), .wb_ctrl_o(wc1), .wb_dst_o(wd1), .stall_o(st1), .flush_o(fl1),
    .pc_sel_o(ps1), .illegal_o(il1));

  pipeline_control #(.ALUOP_W(3), .REG_W(5), .FWD_EN(1'b0)) u0 (
    .clk_i(clk), .rst_i(rst), .op_i(op), .funct_i(funct), .rs_i(rs), .rt_i(rt), .rd_i(rd),
    .eq_i(eq), .ex_ctrl_o(ex_ctrl0), .ex_fwd_a_o(fa0), .ex_fwd_b_o(fb0), .mem_ctrl_o(mc0),
    .mem_dst_o(md0), .wb_ctrl_o(wc0), .wb_dst_o(wd0), .stall_o(st0), .flush_o(fl0),
    .pc_sel_o(ps0), .illegal_o(il0));

  logic [26:0] act1, act0;
  assign act1 = {ex_ctrl1, fa1, fb1, mc1, md1, wc1, wd1, st1, fl1, ps1, il1};
  assign act0 = {ex_ctrl0, fa0, fb0, mc0, md0, wc0, wd0, st0, fl0, ps0, il0};

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // One record per in-flight instruction: what it does and which registers it reads.
  typedef struct packed {
    logic [2:0] alu;
    logic       src, cs, we, rwe, m2r;
    logic [4:0] dst;
    logic       ill, br;
    logic [4:0] rs, rt;
  } inst_t;

  // Pipeline occupancy per instance: [0]=EX, [1]=MEM, [2]=WB.
  inst_t m1 [3];
  inst_t m0 [3];

  function automatic inst_t decode(input logic [5:0] o, input logic [5:0] f,
                                   input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    inst_t x = '0;
    bit rd_s = 1, rd_t = 0;
    if (o == OP_R) begin
      rd_t = 1;
      x.rwe = 1; x.dst = d;
      if      (f == FN_ADD) x.alu = 3'b010;
      else if (f == FN_SUB) x.alu = 3'b110;
      else if (f == FN_AND) x.alu = 3'b000;
      else if (f == FN_OR)  x.alu = 3'b001;
      else if (f == FN_MUL) x.alu = 3'b011;
      else begin x.rwe = 0; x.dst = 0; x.ill = 1; end
    end else if (o == OP_ADDI) begin
      x.alu = 3'b010; x.src = 1; x.rwe = 1; x.dst = t;
    end else if (o == OP_LW) begin
      x.alu = 3'b010; x.src = 1; x.cs = 1; x.rwe = 1; x.m2r = 1; x.dst = t;
    end else if (o == OP_SW) begin
      rd_t = 1; x.alu = 3'b010; x.src = 1; x.cs = 1; x.we = 1;
    end else if (o == OP_BEQ) begin
      rd_t = 1; x.alu = 3'b110; x.br = 1;
    end else if (o == OP_J) begin
      rd_s = 0;
    end else begin
      x.ill = 1;
    end
    x.rs = rd_s ? s : 5'd0;
    x.rt = rd_t ? t : 5'd0;
    return x;
  endfunction

  function automatic bit writes(input inst_t x, input logic [4:0] r);
    return x.rwe && x.dst != 5'd0 && x.dst == r;
  endfunction

  // [27] = ID/EX squashed at next edge, [26:0] = expected output bundle.
  function automatic logic [27:0] predict(input inst_t ex, input inst_t mem, input inst_t wb,
                                          input bit fwd, input logic r,
                                          input logic [5:0] o, input logic [5:0] f,
                                          input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic e);
    inst_t id;
    bit hex, hmem, cond, taken, jump, stall;
    logic [1:0] fa, fb, pc;
    if (r) return '0;
    id    = decode(o, f, s, t, d);
    hex   = writes(ex, id.rs) || writes(ex, id.rt);
    hmem  = writes(mem, id.rs) || writes(mem, id.rt);
    cond  = fwd ? (hex && ex.m2r) : (hex || hmem);
    taken = ex.br && e;
    stall = cond && !taken;
    jump  = (o == OP_J) && !taken && !cond;
    fa = !fwd ? 2'd0 : writes(mem, ex.rs) ? 2'd2 : writes(wb, ex.rs) ? 2'd1 : 2'd0;
    fb = !fwd ? 2'd0 : writes(mem, ex.rt) ? 2'd2 : writes(wb, ex.rt) ? 2'd1 : 2'd0;
    pc = taken ? 2'd1 : jump ? 2'd2 : 2'd0;
    return {(cond || taken), ex.alu, ex.src, fa, fb, mem.cs, mem.we, mem.dst,
            wb.rwe, wb.m2r, wb.dst, stall, (taken || jump), pc, ex.ill};
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [27:0] p1, p0;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin m1[i] = '0; m0[i] = '0; end
    end else begin
      p1 = predict(m1[0], m1[1], m1[2], 1'b1, 1'b0, op, funct, rs, rt, rd, eq);
      p0 = predict(m0[0], m0[1], m0[2], 1'b0, 1'b0, op, funct, rs, rt, rd, eq);
      m1[2] = m1[1]; m1[1] = m1[0];
      m1[0] = p1[27] ? inst_t'('0) : decode(op, funct, rs, rt, rd);
      m0[2] = m0[1]; m0[1] = m0[0];
      m0[0] = p0[27] ? inst_t'('0) : decode(op, funct, rs, rt, rd);
    end
  end

  // Compare process: every cycle, both instances, all outputs.
  always @(negedge clk) begin
    logic [27:0] x1, x0;
    x1 = predict(m1[0], m1[1], m1[2], 1'b1, rst, op, funct, rs, rt, rd, eq);
    x0 = predict(m0[0], m0[1], m0[2], 1'b0, rst, op, funct, rs, rt, rd, eq);
    checks++;
    if (act1 !== x1[26:0]) begin
      errors++;
      $display("FAIL model_fwd1 t=%0t got %h want %h", $time, act1, x1[26:0]);
    end
    checks++;
    if (act0 !== x0[26:0]) begin
      errors++;
      $display("FAIL model_fwd0 t=%0t got %h want %h", $time, act0, x0[26:0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Presents one instruction in ID for one cycle; returns just after the negedge.
  task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d, input logic e);
    @(posedge clk); #1;
    op = o; funct = f; rs = s; rt = t; rd = d; eq = e;
    @(negedge clk); #1;
  endtask

  task automatic nop();
    issue(OP_SW, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic drain();
    repeat (3) nop();
  endtask

  initial begin
    // Reset with J in ID: combinational outputs must stay quiet.
    #2;
    chk("rst_pc_sel", {30'd0, ps1}, 32'd0);
    chk("rst_flush", {31'd0, fl1}, 32'd0);
    chk("rst_bundle0", {5'd0, act0}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    drain();

    // EX/MEM forwarding, no stall with forwarding.
    issue(OP_R, FN_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
    issue(OP_R, FN_SUB, 5'd3, 5'd4, 5'd5, 1'b0);
    chk("fwd_no_stall", {31'd0, st1}, 32'd0);
    chk("nofwd_stall", {31'd0, st0}, 32'd1);
    nop();
    chk("fwd_a_exmem", {30'd0, fa1}, 32'd2);
    chk("sub_ex_ctrl", {28'd0, ex_ctrl1}, 32'hC);
    chk("fwd_no_stall2", {31'd0, st1}, 32'd0);
    drain();

    // Load-use: one stall, bubble, then MEM/WB forward.
    issue(OP_LW, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
    issue(OP_R, FN_ADD, 5'd3, 5'd2, 5'd4, 1'b0);
    chk("lu_stall", {31'd0, st1}, 32'd1);
    issue(OP_R, FN_ADD, 5'd3, 5'd2, 5'd4, 1'b0);
    chk("lu_stall_end", {31'd0, st1}, 32'd0);
    chk("lu_bubble", {28'd0, ex_ctrl1}, 32'd0);
    nop();
    chk("lu_fwd_b", {30'd0, fb1}, 32'd1);
    chk("lu_fwd_a", {30'd0, fa1}, 32'd0);
    chk("lu_wb_ctrl", {30'd0, wc1}, 32'd3);
    drain();

    // No forwarding: two stall cycles.
    issue(OP_R, FN_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
    issue(OP_R, FN_ADD, 5'd3, 5'd3, 5'd6, 1'b0);
    chk("nf_stall1", {31'd0, st0}, 32'd1);
    chk("nf_fa1", {30'd0, fa0}, 32'd0);
    issue(OP_R, FN_ADD, 5'd3, 5'd3, 5'd6, 1'b0);
    chk("nf_stall2", {31'd0, st0}, 32'd1);
    chk("nf_fb2", {30'd0, fb0}, 32'd0);
    issue(OP_R, FN_ADD, 5'd3, 5'd3, 5'd6, 1'b0);
    chk("nf_stall3", {31'd0, st0}, 32'd0);
    nop();
    chk("nf_ex_ctrl", {28'd0, ex_ctrl0}, 32'h4);
    chk("nf_fsel", {28'd0, fa0, fb0}, 32'd0);
    drain();

    // Taken branch beats J in ID.
    issue(OP_BEQ, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0);
    issue(OP_J, 6'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    chk("br_pc_sel", {30'd0, ps1}, 32'd1);
    chk("br_flush", {31'd0, fl1}, 32'd1);
    nop();
    chk("br_ex_bubble", {28'd0, ex_ctrl1}, 32'd0);
    chk("br_mem_ctrl", {30'd0, mc1}, 32'd0);
    issue(OP_J, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("j_pc_sel", {30'd0, ps1}, 32'd2);
    chk("j_flush", {31'd0, fl1}, 32'd1);
    drain();

    // Register 0 never stalls nor forwards.
    issue(OP_R, FN_ADD, 5'd1, 5'd2, 5'd0, 1'b0);
    issue(OP_R, FN_ADD, 5'd0, 5'd0, 5'd4, 1'b0);
    chk("r0_stall1", {31'd0, st1}, 32'd0);
    chk("r0_stall0", {31'd0, st0}, 32'd0);
    nop();
    chk("r0_fsel", {28'd0, fa1, fb1}, 32'd0);
    nop();
    chk("r0_wb_ctrl", {30'd0, wc1}, 32'd2);
    chk("r0_wb_dst", {27'd0, wd1}, 32'd0);
    drain();

    // Undefined opcode.
    issue(OP_BAD, 6'd0, 5'd1, 5'd2, 5'd3, 1'b0);
    nop();
    chk("ill_flag", {31'd0, il1}, 32'd1);
    chk("ill_ctrl", {28'd0, ex_ctrl1}, 32'd0);
    drain();

    // Randomized stream with periodic asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      int k;
      logic [5:0] o, f;
      k = $urandom_range(0, 11);
      f = 6'($urandom);
      case (k)
        0: begin o = OP_R; f = FN_ADD; end
        1: begin o = OP_R; f = FN_SUB; end
        2: begin o = OP_R; f = FN_AND; end
        3: begin o = OP_R; f = FN_OR;  end
        4: begin o = OP_R; f = FN_MUL; end
        5: begin o = OP_R; f = FN_BAD; end
        6: o = OP_ADDI;
        7: o = OP_LW;
        8: o = OP_SW;
        9: o = OP_BEQ;
        10: o = OP_J;
        default: o = OP_BAD;
      endcase
      issue(o, f, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if (n % 500 == 499) begin
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst_async_u1", {5'd0, act1}, 32'd0);
        chk("rst_async_u0", {5'd0, act0}, 32'd0);
        @(posedge clk); #3;
        rst = 1'b0;
      end
    end

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
